// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory port, redirect input and the decode handshake.
// The master modport is the fetch sequencer; the slave modport is the memory/decode side.
interface fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, fetches from a combinational ROM, hands words to decode.
// Optional HALT_ON_NOP_EN: an all-zero word is presented and then the sequencer halts.
module fetch_sequencer #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    fetch_sequencer_if.master bus,
    output logic              halted,
    output logic [31:0]       fetch_count
);
    localparam int unsigned     AW      = $clog2(MEM_DEPTH) + 2;
    localparam logic [AW-1:0]   PC_INIT = {RESET_PC[AW-1:2], 2'b00};

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic          fire;

    assign fire          = bus.instr_valid && bus.instr_ready;
    assign bus.imem_addr = {{(DATA_WIDTH-AW){1'b0}}, pc};

`ifndef HALT_ON_NOP_EN
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= PC_INIT;
            bus.instr_valid <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            fetch_count     <= '0;
`ifdef HALT_ON_NOP_EN
            halted          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= PC_INIT;
                    end
                end
                RUN: begin
                    // A redirect squashes the presented word even if decode is ready.
                    if (bus.redirect_valid) begin
                        bus.instr_valid <= 1'b0;
                        pc              <= {bus.redirect_pc[AW-1:2], 2'b00};
                    end else if (!bus.instr_valid || bus.instr_ready) begin
                        if (fire)
                            fetch_count <= fetch_count + 32'd1;
                        bus.instr       <= bus.imem_instr;
                        bus.instr_pc    <= {{(DATA_WIDTH-AW){1'b0}}, pc};
                        bus.instr_valid <= 1'b1;
`ifdef HALT_ON_NOP_EN
                        if (bus.imem_instr == '0) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + AW'(4);
                        end
`else
                        pc <= pc + AW'(4);
`endif
                    end
                end
                HALT: begin
                    // The last presented word may still drain while halted.
                    if (fire) begin
                        fetch_count     <= fetch_count + 32'd1;
                        bus.instr_valid <= 1'b0;
                    end
                    if (start) begin
                        state <= RUN;
                        pc    <= PC_INIT;
`ifdef HALT_ON_NOP_EN
                        halted <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
